// File: rtl/fp_mult_unit.sv
// Sequential IEEE-754 binary32 multiplier (radix-2 shift-add, FTZ in and out).
// Latency: 27 cycles from accepted start to ready; 1 cycle for NaN/Inf/zero operands.
// Backpressure: none; starts arriving while busy are dropped. Optional macro FP_MULT_ROUND_EN selects RNE, else truncation.
module fp_mult_unit #(
  parameter int EXP_WIDTH  = 8,
  parameter int FRAC_WIDTH = 23,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  mult_start,
  input  logic [DATA_WIDTH-1:0] operand_a,
  input  logic [DATA_WIDTH-1:0] operand_b,
  output logic [DATA_WIDTH-1:0] mult_result,
  output logic                  mult_data_ready,
  output logic                  mult_busy
);

  localparam int SIG_W  = FRAC_WIDTH + 1;   // significand with hidden bit
  localparam int PROD_W = 2 * SIG_W;        // full product width
  localparam int EXPS_W = EXP_WIDTH + 2;    // signed exponent with headroom
  localparam int BIAS   = (1 << (EXP_WIDTH - 1)) - 1;

  localparam logic [EXP_WIDTH-1:0]         EXP_ALL1  = '1;
  localparam logic signed [EXPS_W-1:0]     EXP_INF   = EXPS_W'((1 << EXP_WIDTH) - 1);
  localparam logic signed [EXPS_W-1:0]     EXP_ZERO  = '0;
  localparam logic [4:0]                   LAST_ITER = 5'(SIG_W - 1);
  localparam logic [DATA_WIDTH-1:0]        QNAN      = {1'b0, EXP_ALL1, 1'b1, {(FRAC_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    UNPACK = 3'd1,
    MULT   = 3'd2,
    NORM   = 3'd3,
    ROUND  = 3'd4
  } state_t;

  state_t                     state_q,  state_d;
  logic [DATA_WIDTH-1:0]      a_q,      a_d;
  logic [DATA_WIDTH-1:0]      b_q,      b_d;
  logic                       sign_q,   sign_d;
  logic [SIG_W-1:0]           ma_q,     ma_d;
  logic [SIG_W-1:0]           mb_q,     mb_d;
  logic signed [EXPS_W-1:0]   exp_q,    exp_d;
  logic [PROD_W-1:0]          prod_q,   prod_d;
  logic [4:0]                 cnt_q,    cnt_d;
  logic [SIG_W-1:0]           sig_q,    sig_d;
`ifdef FP_MULT_ROUND_EN
  logic                       guard_q,  guard_d;
  logic                       sticky_q, sticky_d;
`endif
  logic [DATA_WIDTH-1:0]      result_q, result_d;
  logic                       ready_q,  ready_d;
  logic                       busy_q,   busy_d;

  // Field views of the captured operands.
  logic                  a_sign, b_sign;
  logic [EXP_WIDTH-1:0]  a_exp,  b_exp;
  logic [FRAC_WIDTH-1:0] a_frac, b_frac;
  logic                  a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

  // Operand classification; exponent 0 covers both zero and subnormal (flushed).
  always_comb begin
    a_sign = a_q[DATA_WIDTH-1];
    b_sign = b_q[DATA_WIDTH-1];
    a_exp  = a_q[DATA_WIDTH-2 -: EXP_WIDTH];
    b_exp  = b_q[DATA_WIDTH-2 -: EXP_WIDTH];
    a_frac = a_q[FRAC_WIDTH-1:0];
    b_frac = b_q[FRAC_WIDTH-1:0];
    a_nan  = (a_exp == EXP_ALL1) && (a_frac != '0);
    b_nan  = (b_exp == EXP_ALL1) && (b_frac != '0);
    a_inf  = (a_exp == EXP_ALL1) && (a_frac == '0);
    b_inf  = (b_exp == EXP_ALL1) && (b_frac == '0);
    a_zero = (a_exp == '0);
    b_zero = (b_exp == '0);
  end

  // Rounding of the normalised significand and the post-round renormalisation.
  logic                     round_inc;
  logic [SIG_W:0]           sig_sum;
  logic [FRAC_WIDTH-1:0]    frac_fin;
  logic signed [EXPS_W-1:0] exp_fin;

  // Round increment, carry-out renormalisation and final exponent.
  always_comb begin
    round_inc = 1'b0;
`ifdef FP_MULT_ROUND_EN
    round_inc = guard_q & (sticky_q | sig_q[0]);
`endif
    sig_sum = {1'b0, sig_q} + (SIG_W+1)'(round_inc);
    if (sig_sum[SIG_W]) begin
      // Carry into 2^24: significand becomes 1.0, exponent bumps.
      frac_fin = sig_sum[SIG_W-1:1];
      exp_fin  = exp_q + EXPS_W'(1);
    end else begin
      frac_fin = sig_sum[FRAC_WIDTH-1:0];
      exp_fin  = exp_q;
    end
  end

  // Next-state and datapath logic; result/ready default to 0 so the OR-combined bus stays clean.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sign_d   = sign_q;
    ma_d     = ma_q;
    mb_d     = mb_q;
    exp_d    = exp_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    sig_d    = sig_q;
`ifdef FP_MULT_ROUND_EN
    guard_d  = guard_q;
    sticky_d = sticky_q;
`endif
    result_d = '0;
    ready_d  = 1'b0;
    busy_d   = busy_q;

    case (state_q)
      IDLE: begin
        if (mult_start) begin
          a_d     = operand_a;
          b_d     = operand_b;
          busy_d  = 1'b1;
          state_d = UNPACK;
        end
      end

      UNPACK: begin
        sign_d = a_sign ^ b_sign;
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
          result_d = QNAN;
          ready_d  = 1'b1;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end else if (a_inf || b_inf) begin
          result_d = {a_sign ^ b_sign, EXP_ALL1, {FRAC_WIDTH{1'b0}}};
          ready_d  = 1'b1;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end else if (a_zero || b_zero) begin
          result_d = {a_sign ^ b_sign, {(DATA_WIDTH-1){1'b0}}};
          ready_d  = 1'b1;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end else begin
          ma_d    = {1'b1, a_frac};
          mb_d    = {1'b1, b_frac};
          exp_d   = EXPS_W'(a_exp) + EXPS_W'(b_exp) - EXPS_W'(BIAS);
          prod_d  = '0;
          cnt_d   = '0;
          state_d = MULT;
        end
      end

      MULT: begin
        // One multiplier bit per cycle, LSB first.
        if (mb_q[cnt_q]) begin
          prod_d = prod_q + (PROD_W'(ma_q) << cnt_q);
        end
        if (cnt_q == LAST_ITER) begin
          cnt_d   = '0;
          state_d = NORM;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end

      NORM: begin
        // Product of two [1,2) significands lies in [1,4); bit 47 flags the [2,4) half.
        if (prod_q[PROD_W-1]) begin
          sig_d    = prod_q[PROD_W-1 -: SIG_W];
`ifdef FP_MULT_ROUND_EN
          guard_d  = prod_q[PROD_W-1-SIG_W];
          sticky_d = |prod_q[PROD_W-2-SIG_W:0];
`endif
          exp_d    = exp_q + EXPS_W'(1);
        end else begin
          sig_d    = prod_q[PROD_W-2 -: SIG_W];
`ifdef FP_MULT_ROUND_EN
          guard_d  = prod_q[PROD_W-2-SIG_W];
          sticky_d = |prod_q[PROD_W-3-SIG_W:0];
`endif
        end
        state_d = ROUND;
      end

      ROUND: begin
        if (exp_fin >= EXP_INF) begin
          result_d = {sign_q, EXP_ALL1, {FRAC_WIDTH{1'b0}}};
        end else if (exp_fin <= EXP_ZERO) begin
          result_d = {sign_q, {(DATA_WIDTH-1){1'b0}}};
        end else begin
          result_d = {sign_q, exp_fin[EXP_WIDTH-1:0], frac_fin};
        end
        ready_d = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State registers; reset abandons any operation in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sign_q   <= 1'b0;
      ma_q     <= '0;
      mb_q     <= '0;
      exp_q    <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      sig_q    <= '0;
`ifdef FP_MULT_ROUND_EN
      guard_q  <= 1'b0;
      sticky_q <= 1'b0;
`endif
      result_q <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sign_q   <= sign_d;
      ma_q     <= ma_d;
      mb_q     <= mb_d;
      exp_q    <= exp_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      sig_q    <= sig_d;
`ifdef FP_MULT_ROUND_EN
      guard_q  <= guard_d;
      sticky_q <= sticky_d;
`endif
      result_q <= result_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
    end
  end

  assign mult_result     = result_q;
  assign mult_data_ready = ready_q;
  assign mult_busy       = busy_q;

endmodule

// File: tb/tb_fp_mult_unit.sv
// Self-checking bench for fp_mult_unit: directed table, corner sequences, random vs reference model.
// Reference model works on whole integers (full product, remainder-vs-half rounding).
// Honours FP_MULT_ROUND_EN the same way the design does.
module tb_fp_mult_unit;

  logic        clock;
  logic        reset;
  logic        mult_start;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [31:0] mult_result;
  logic        mult_data_ready;
  logic        mult_busy;

  int n_checks = 0;
  int n_fail   = 0;

  fp_mult_unit dut (
    .clock           (clock),
    .reset           (reset),
    .mult_start      (mult_start),
    .operand_a       (operand_a),
    .operand_b       (operand_b),
    .mult_result     (mult_result),
    .mult_data_ready (mult_data_ready),
    .mult_busy       (mult_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: product of integer significands, exponent bookkeeping, rounding by remainder.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output int lat);
    int          ea, eb, e, sh;
    logic        s;
    logic        an, bn, ai, bi, az, bz;
    longint unsigned p, keep, rem, half;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    s  = a[31] ^ b[31];
    an = (ea == 255) && (a[22:0] != 0);
    bn = (eb == 255) && (b[22:0] != 0);
    ai = (ea == 255) && (a[22:0] == 0);
    bi = (eb == 255) && (b[22:0] == 0);
    az = (ea == 0);
    bz = (eb == 0);
    lat = 1;
    if (an || bn || (ai && bz) || (bi && az)) r = 32'h7FC00000;
    else if (ai || bi) r = {s, 8'hFF, 23'h0};
    else if (az || bz) r = {s, 31'h0};
    else begin
      lat  = 27;
      p    = longint'({1'b1, a[22:0]}) * longint'({1'b1, b[22:0]});
      e    = ea + eb - 127;
      sh   = (p >= (64'd1 << 47)) ? 24 : 23;
      if (sh == 24) e++;
      keep = p >> sh;
      rem  = p - (keep << sh);
      half = 64'd1 << (sh - 1);
`ifdef FP_MULT_ROUND_EN
      if (rem > half || (rem == half && keep[0])) keep++;
`else
      if (rem > p) keep++;  // never true: truncation discards the remainder
`endif
      if (keep == (64'd1 << 24)) begin
        keep = keep >> 1;
        e++;
      end
      if (e >= 255) r = {s, 8'hFF, 23'h0};
      else if (e <= 0) r = {s, 31'h0};
      else r = {s, 8'(e), keep[22:0]};
    end
  endfunction

  // Drive a one-cycle start; returns at E0 + 1.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    operand_a  = a;
    operand_b  = b;
    mult_start = 1'b1;
    @(posedge clock);
    #1;
    mult_start = 1'b0;
  endtask

  // Wait for ready, counting edges after E0; flags busy/result-bus misbehaviour on the way.
  task automatic wait_ready(input int bound, output int lat, output logic [31:0] res,
                            output int bad_busy, output int bad_zero);
    lat = -1;
    res = '0;
    bad_busy = 0;
    bad_zero = 0;
    for (int k = 1; k <= bound; k++) begin
      @(posedge clock);
      #1;
      if (mult_data_ready) begin
        lat = k;
        res = mult_result;
        if (mult_busy) bad_busy++;
        break;
      end
      if (mult_result != 32'h0) bad_zero++;
      if (!mult_busy) bad_busy++;
    end
  endtask

  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int exp_lat);
    int          lat, bb, bz;
    logic [31:0] res;
    start_op(a, b);
    check({name, "_busy_at_start"}, 32'(mult_busy), 32'd1);
    wait_ready(40, lat, res, bb, bz);
    check({name, "_result"}, res, exp_res);
    check({name, "_latency"}, 32'(lat), 32'(exp_lat));
    check({name, "_busy"}, 32'(bb), 32'd0);
    check({name, "_bus_zero_before"}, 32'(bz), 32'd0);
    @(posedge clock);
    #1;
    check({name, "_bus_zero_after"}, {mult_result[31:1], mult_result[0] | mult_data_ready}, 32'h0);
  endtask

  function automatic logic [31:0] rand_fp();
    logic [31:0] v;
    int          sel;
    sel      = $urandom_range(0, 19);
    v[31]    = 1'($urandom_range(0, 1));
    v[22:0]  = 23'($urandom);
    case (sel)
      0:       v[30:23] = 8'h00;
      1:       v[30:23] = 8'hFF;
      2:       begin v[30:23] = 8'hFF; v[22:0] = '0; end
      3:       v[30:23] = 8'($urandom_range(200, 254));
      4:       v[30:23] = 8'($urandom_range(1, 50));
      5:       v[22:0]  = 23'h7FFFFF;
      default: v[30:23] = 8'($urandom_range(64, 190));
    endcase
    if (sel == 5) v[30:23] = 8'($urandom_range(100, 150));
    return v;
  endfunction

  vec_t vecs[12];

  initial begin
    int          lat, bb, bz, n_ready;
    logic [31:0] res, ra, rb, er;
    int          el;

    vecs[0]  = '{32'h40000000, 32'h40400000, 32'h40C00000, 27};
`ifdef FP_MULT_ROUND_EN
    vecs[1]  = '{32'h3FC00001, 32'h3FC00001, 32'h40100002, 27};
`else
    vecs[1]  = '{32'h3FC00001, 32'h3FC00001, 32'h40100001, 27};
`endif
    vecs[2]  = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 1};
    vecs[3]  = '{32'hFF800000, 32'h40000000, 32'hFF800000, 1};
    vecs[4]  = '{32'h7F000000, 32'h7F000000, 32'h7F800000, 27};
    vecs[5]  = '{32'h00800000, 32'h00800000, 32'h00000000, 27};
    vecs[6]  = '{32'h80800000, 32'h00800000, 32'h80000000, 27};
    vecs[7]  = '{32'h7FC12345, 32'h3F800000, 32'h7FC00000, 1};
    vecs[8]  = '{32'h80400000, 32'h40000000, 32'h80000000, 1};
    vecs[9]  = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 27};
    vecs[10] = '{32'hC0000000, 32'h3FC00000, 32'hC0400000, 27};
    vecs[11] = '{32'h00000000, 32'hFF800000, 32'h7FC00000, 1};

    reset      = 1'b0;
    mult_start = 1'b0;
    operand_a  = '0;
    operand_b  = '0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_result", mult_result, 32'h0);
    check("reset_ready", 32'(mult_data_ready), 32'd0);
    check("reset_busy", 32'(mult_busy), 32'd0);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("idle_after_reset", {29'h0, mult_busy, mult_data_ready, |mult_result}, 32'h0);

    // Directed table.
    for (int i = 0; i < 12; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat);
    end

    // Start while busy is ignored; start in the ready cycle is accepted.
    start_op(32'h3FC00000, 32'h3FC00000);
    n_ready = 0;
    lat = -1;
    res = '0;
    for (int k = 1; k <= 27; k++) begin
      if (k == 10) begin
        operand_a  = 32'h40000000;
        operand_b  = 32'h40000000;
        mult_start = 1'b1;
      end
      @(posedge clock);
      #1;
      mult_start = 1'b0;
      if (mult_data_ready) begin
        n_ready++;
        lat = k;
        res = mult_result;
      end
    end
    check("busy_ignore_ready_count", 32'(n_ready), 32'd1);
    check("busy_ignore_latency", 32'(lat), 32'd27);
    check("busy_ignore_result", res, 32'h40100000);
    start_op(32'h40000000, 32'h40400000);
    wait_ready(40, lat, res, bb, bz);
    check("ready_cycle_start_result", res, 32'h40C00000);
    check("ready_cycle_start_latency", 32'(lat), 32'd27);
    check("ready_cycle_start_busy", 32'(bb), 32'd0);
    @(posedge clock);
    #1;

    // Reset mid-operation.
    start_op(32'h3FC00000, 32'h3FC00000);
    repeat (12) begin
      @(posedge clock);
      #1;
    end
    check("busy_before_midreset", 32'(mult_busy), 32'd1);
    reset = 1'b0;
    #1;
    check("midreset_result", mult_result, 32'h0);
    check("midreset_busy", 32'(mult_busy), 32'd0);
    n_ready = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clock);
      #1;
      if (k == 3) reset = 1'b1;
      if (mult_data_ready) n_ready++;
    end
    check("midreset_no_ready", 32'(n_ready), 32'd0);
    run_op("after_reset", 32'h3F800000, 32'h3F800000, 32'h3F800000, 27);

    // Randomized against the reference model.
    for (int i = 0; i < 150; i++) begin
      ra = rand_fp();
      rb = rand_fp();
      model(ra, rb, er, el);
      start_op(ra, rb);
      wait_ready(40, lat, res, bb, bz);
      n_checks++;
      if (res !== er || lat != el || bb != 0 || bz != 0) begin
        n_fail++;
        $display("FAIL rand%0d %h*%h: got %h lat %0d (busy err %0d, bus err %0d) expected %h lat %0d",
                 i, ra, rb, res, lat, bb, bz, er, el);
      end
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clock);
        #1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_mult_unit.md
# fp_mult_unit

Sequential IEEE-754 binary32 multiplier that serves the term accumulator's multiply requests: it accepts a one-cycle `mult_start` with two operands and returns the product with a one-cycle `mult_data_ready` pulse. It sits directly downstream of the term accumulator. Its result bus is OR-combined with the add, divide and exponent results, so it must be zero at every moment except the ready cycle.

## Interface
- `EXP_WIDTH`, default 8: exponent field width.
- `FRAC_WIDTH`, default 23: fraction field width.
- `DATA_WIDTH`, default 32: operand and result width; must equal 1+`EXP_WIDTH`+`FRAC_WIDTH`. Only the default set is supported.
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `mult_start`  in  1  one-cycle request; sampled only in IDLE.
- `operand_a`  in  `DATA_WIDTH`  multiplicand; captured on the edge that accepts `mult_start`.
- `operand_b`  in  `DATA_WIDTH`  multiplier; captured on the same edge.
- `mult_result`  out  `DATA_WIDTH`  product; valid only while `mult_data_ready`=1, and 0 otherwise.
- `mult_data_ready`  out  1  one-cycle completion pulse.
- `mult_busy`  out  1  high from acceptance of a start until the ready cycle, exclusive.

## Operation
- States:
  - IDLE → UNPACK on `mult_start`=1.
  - UNPACK → MULT, or → IDLE with the result issued if the operands form a special case.
  - MULT runs 24 iterations, then → NORM.
  - NORM → ROUND.
  - ROUND → IDLE with the result issued.
- UNPACK:
  - Sign = sa XOR sb.
  - Significands get the hidden bit prepended (24 bits).
  - Exponent sum = ea+eb−127, held in a 10-bit signed register.
- Special cases, in priority order:
  - Either operand NaN, or Inf×0 → canonical NaN 0x7FC00000.
  - Either operand Inf → signed Inf.
  - Either operand zero or subnormal → signed zero. Subnormal inputs are flushed to zero (FTZ).
- MULT: radix-2 shift-add, one multiplier bit per cycle, LSB first, into a 48-bit product. A 5-bit counter runs 0..23.
- NORM:
  - If product bit 47 is set: shift right 1 and increment the exponent.
  - Keep 24 significand bits, a guard bit, and a sticky bit (OR of the remaining bits).
- ROUND:
  - Apply the rounding mode (see Configuration).
  - If rounding overflows the significand to 2^24: shift right and increment the exponent.
  - Exponent ≥255 → signed Inf (0x7F800000 | sign).
  - Exponent ≤0 → signed zero (FTZ output).
  - Otherwise pack sign, exponent[7:0] and the 23-bit fraction.
- `mult_start` while busy is ignored: no queuing, and captured operands are unchanged.
- `mult_start` in the ready cycle is accepted, since the FSM is already in IDLE.

## Timing
- Reset values: `mult_result`=0, `mult_data_ready`=0, `mult_busy`=0, state IDLE, counter 0, all datapath registers 0.
- The start is sampled at edge E0.
- Normal case: `mult_data_ready` and `mult_result` are registered at E27 and visible for exactly the one cycle after E27. Latency is 27 cycles.
- Special case: result registered at E1. Latency is 1 cycle.
- `mult_busy` is registered high at E0 and registered low on the same edge that raises ready.
- Reset asserted mid-operation: the FSM is abandoned immediately and no ready pulse is produced. The first start after reset release behaves as from power-up.
- The outputs are registers only, with no combinational path from inputs to outputs.

## Configuration
- `FP_MULT_ROUND_EN` defined: ROUND performs round-to-nearest-even. Increment when guard=1 AND (sticky=1 OR lsb=1).
- `FP_MULT_ROUND_EN` undefined: ROUND truncates. Guard and sticky are ignored; the ROUND state and its latency are unchanged.

## Test plan
- 0x40000000 × 0x40400000 (2.0×3.0) → `mult_result`=0x40C00000 with ready exactly 27 cycles after start; `mult_result`=0 on the cycles before and after.
- 0x3FC00001 × 0x3FC00001 → 0x40100002 with `FP_MULT_ROUND_EN` defined; 0x40100001 without.
- 0x7F800000 × 0x00000000 → 0x7FC00000 after 1 cycle. 0xFF800000 × 0x40000000 → 0xFF800000 after 1 cycle.
- Overflow and underflow:
  - 0x7F000000 × 0x7F000000 → 0x7F800000.
  - 0x00800000 × 0x00800000 → 0x00000000.
  - 0x80800000 × 0x00800000 → 0x80000000.
- Start 0x3FC00000×0x3FC00000. At cycle 10, pulse start with 0x40000000×0x40000000 → only one ready, result 0x40100000. A new start in the ready cycle is accepted, and its result follows 27 cycles later.
- Drive `reset` low at cycle 12 of an operation → outputs 0 immediately and no ready pulse. After release, 0x3F800000 × 0x3F800000 → 0x3F800000 at 27 cycles.
